// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the request legality check.
package lsu_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_e;

  // A request is rejected without touching memory when it is misaligned for its
  // size, uses the illegal size code, or falls outside data_mem.
  function automatic logic req_bad(input size_e size, input logic [31:0] addr,
                                   input logic [31:0] limit);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || (addr >= limit);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake between the EX/MEM pipeline register, the LSU and WB.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  // Pipeline side: issues requests and consumes responses.
  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  // LSU side.
  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Little-endian lane handling: extracts and extends sub-word loads from a data_mem
// word, and merges sub-word store data into the word read back for RMW.
module lsu_align
  import lsu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    load_data  = rdata;
    merge_data = rdata;
    byte_lane  = rdata[{offset, 3'b000} +: 8];
    half_lane  = rdata[{offset[1], 4'b0000} +: 16];

    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
        merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & half_lane[15]}}, half_lane};
        merge_data[{offset[1], 4'b0000} +: 16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time, word-only data_mem with a
// 1-cycle registered read, sub-word stores done as read-modify-write.
module mem_lsu
  import lsu_defs::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_lsu_if.slave      bus,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  input  logic [31:0]   dm_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_e      state, state_d;
  logic        store_q;
  logic        signed_q;
  size_e       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_err;
  size_e       req_size;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  assign req_size = size_e'(bus.req_size);
  assign accept   = bus.req_valid && (state == ST_IDLE);
  assign req_err  = req_bad(req_size, bus.req_addr, ADDR_LIMIT);

  lsu_align u_align (
    .rdata      (dm_rdata),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_ext),
    .merge_data (merge_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                               state_d = ST_RESP;
          else if (bus.req_store && req_size == SZ_WORD) state_d = ST_WR;
          else                                       state_d = ST_RD;
        end
      end
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = store_q ? ST_WR : ST_RESP;
      ST_WR:      state_d = ST_RESP;
      ST_RESP:    if (bus.resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request, merge and response registers. resp_data is cleared at accept so
  // stores and rejected requests answer with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        store_q     <= bus.req_store;
        signed_q    <= bus.req_signed;
        size_q      <= req_size;
        addr_q      <= bus.req_addr;
        wdata_q     <= bus.req_wdata;
        resp_data_q <= '0;
        resp_err_q  <= req_err;
      end
      if (state == ST_RD_WAIT) begin
        if (store_q) merge_q     <= merge_word;
        else         resp_data_q <= load_ext;
      end
    end
  end

  // Memory-side outputs decode from registered state only.
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_we    = (state == ST_WR);
  assign dm_wdata = (state == ST_WR) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  a_we_single: assert property (@(posedge clk) disable iff (!rst_n) dm_we |=> !dm_we);

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.resp_valid && !bus.resp_ready) |=>
      (bus.resp_valid && $stable(bus.resp_data) && $stable(bus.resp_err)));

  a_no_we_on_err: assert property (@(posedge clk) disable iff (!rst_n)
    (accept && req_err) |=> (state == ST_RESP));

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural word-only data_mem (word 4 = 100).
module tb_mem_lsu;
  import lsu_defs::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  mem_lsu_if bus ();

  mem_lsu #(.MEM_WORDS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem: word access, 1-cycle registered read.
  logic [31:0] mem [32] = '{4: 32'd100, default: 32'd0};
  int          we_count = 0;

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[6:2]] <= dm_wdata;
    dm_rdata <= mem[dm_addr[6:2]];
    if (dm_we) we_count <= we_count + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
    logic        err;
    int          we;
  } vec_t;

  vec_t vecs [17];

  task automatic drive_req(input logic store, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_store  = store;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Called #1 after a rising edge with the LSU idle. Latency counts the accept
  // edge as 1 up to the edge after which resp_valid is seen.
  task automatic run_vec(input vec_t v);
    int          lat;
    int          we0;
    logic [31:0] d;
    logic        e;
    we0 = we_count;
    drive_req(v.store, v.size, v.sgn, v.addr, v.wdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = bus.resp_data;
    e = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " resp_data"}, d, v.data);
    check({v.name, " resp_err"}, 32'(e), 32'(v.err));
    check({v.name, " dm_we pulses"}, 32'(we_count - we0), 32'(v.we));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_data"},  bus.resp_data, 32'd0);
    check({tag, " resp_err"},   32'(bus.resp_err), 32'd0);
    check({tag, " dm_we"},      32'(dm_we), 32'd0);
    check({tag, " dm_addr"},    dm_addr, 32'd0);
    check({tag, " dm_wdata"},   dm_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          we0;

    vecs[0]  = '{"ld word @16",        1'b0, 2'b10, 1'b0, 32'd16,  32'h0,        3, 32'd100,      1'b0, 0};
    vecs[1]  = '{"st byte AB @17",     1'b1, 2'b00, 1'b0, 32'd17,  32'h0000_00AB, 4, 32'h0,       1'b0, 1};
    vecs[2]  = '{"ld sbyte @17",       1'b0, 2'b00, 1'b1, 32'd17,  32'h0,        3, 32'hFFFF_FFAB, 1'b0, 0};
    vecs[3]  = '{"ld ubyte @17",       1'b0, 2'b00, 1'b0, 32'd17,  32'h0,        3, 32'h0000_00AB, 1'b0, 0};
    vecs[4]  = '{"ld uhalf @16",       1'b0, 2'b01, 1'b0, 32'd16,  32'h0,        3, 32'h0000_AB64, 1'b0, 0};
    vecs[5]  = '{"st half @19 misal",  1'b1, 2'b01, 1'b0, 32'd19,  32'h0000_1234, 1, 32'h0,       1'b1, 0};
    vecs[6]  = '{"ld word @2 misal",   1'b0, 2'b10, 1'b0, 32'd2,   32'h0,        1, 32'h0,        1'b1, 0};
    vecs[7]  = '{"ld word @128 oor",   1'b0, 2'b10, 1'b0, 32'd128, 32'h0,        1, 32'h0,        1'b1, 0};
    vecs[8]  = '{"ld size11 @16",      1'b0, 2'b11, 1'b0, 32'd16,  32'h0,        1, 32'h0,        1'b1, 0};
    vecs[9]  = '{"st word @20",        1'b1, 2'b10, 1'b0, 32'd20,  32'hDEAD_BEEF, 2, 32'h0,       1'b0, 1};
    vecs[10] = '{"ld shalf @22",       1'b0, 2'b01, 1'b1, 32'd22,  32'h0,        3, 32'hFFFF_DEAD, 1'b0, 0};
    vecs[11] = '{"st half @20",        1'b1, 2'b01, 1'b0, 32'd20,  32'hFFFF_1234, 4, 32'h0,       1'b0, 1};
    vecs[12] = '{"ld word @20",        1'b0, 2'b10, 1'b0, 32'd20,  32'h0,        3, 32'hDEAD_1234, 1'b0, 0};
    vecs[13] = '{"ld sbyte @21 pos",   1'b0, 2'b00, 1'b1, 32'd21,  32'h0,        3, 32'h0000_0012, 1'b0, 0};
    vecs[14] = '{"st byte @127 last",  1'b1, 2'b00, 1'b0, 32'd127, 32'h005A_5A55, 4, 32'h0,       1'b0, 1};
    vecs[15] = '{"ld word @124",       1'b0, 2'b10, 1'b0, 32'd124, 32'h0,        3, 32'h5500_0000, 1'b0, 0};
    vecs[16] = '{"st word @128 oor",   1'b1, 2'b10, 1'b0, 32'd128, 32'h1111_1111, 1, 32'h0,       1'b1, 0};

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    check("word4 after table", mem[4], 32'h0000_AB64);
    check("word5 after table", mem[5], 32'hDEAD_1234);
    check("word31 after table", mem[31], 32'h5500_0000);
    check("word0 untouched", mem[0], 32'h0);

    // Backpressure: hold resp_ready low with another request queued.
    drive_req(1'b0, 2'b10, 1'b0, 32'd20, 32'h0);
    @(posedge clk); #1;
    drive_req(1'b1, 2'b10, 1'b0, 32'd16, 32'hFFFF_FFFF);
    we0 = we_count;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stall resp_valid", 32'(bus.resp_valid), 32'd1);
    held = 32'hDEAD_1234;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall c%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("stall c%0d resp_data", i), bus.resp_data, held);
      check($sformatf("stall c%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("stall back to idle", 32'(bus.req_ready), 32'd1);
    check("stall queued not taken we", 32'(we_count - we0), 32'd0);
    check("stall queued not taken word4", mem[4], 32'h0000_AB64);

    // Reset during RD_WAIT of a byte store abandons the RMW.
    we0 = we_count;
    drive_req(1'b1, 2'b00, 1'b0, 32'd16, 32'h0000_0077);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-RMW reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid-RMW reset no we", 32'(we_count - we0), 32'd0);
    check("mid-RMW reset word4", mem[4], 32'h0000_AB64);
    check("post-reset req_ready", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
